// File: rtl/seq1011_pkg.sv
// Shared types for the 1011 Moore sequence detector: state encoding and pattern length.
package seq1011_pkg;

    localparam int PATTERN_LEN = 4;

    // Explicit 3-bit encoding; codes 6 and 7 are illegal and recover to ST_A.
    typedef enum logic [2:0] {
        ST_A = 3'd0,    // idle, nothing matched
        ST_B = 3'd1,    // matched "1"
        ST_C = 3'd2,    // matched "10"
        ST_D = 3'd3,    // matched "101"
        ST_E = 3'd4,    // matched "1011", detection cycle
        ST_F = 3'd5     // sticky post-detection hold
    } state_t;

endpackage

// File: rtl/seq1011_moore_detector_if.sv
// Signal bundle for driving and observing the 1011 detector.
// The master side feeds the serial bit; the slave side returns the state indicators.
interface seq1011_moore_detector_if;

    logic in_bit;
    logic out;
    logic A;
    logic B;
    logic C;
    logic D;
    logic E;
    logic F;

    modport master (
        output in_bit,
        input  out, A, B, C, D, E, F
    );

    modport slave (
        input  in_bit,
        output out, A, B, C, D, E, F
    );

endinterface

// File: rtl/seq1011_moore_detector.sv
// Moore FSM detecting serial pattern 1-0-1-1, with one-hot state indicators A..F.
// Build option SEQ1011_OVERLAP_EN: on mismatch, fall back to the longest matching prefix.
module seq1011_moore_detector
    import seq1011_pkg::*;
(
    input  logic flux,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F
);

    state_t r_state;
    state_t w_next_state;

    // E and F never look at the input, so an X there cannot disturb the state.
    always_comb begin
        w_next_state = ST_A;
        case (r_state)
            ST_A: w_next_state = in ? ST_B : ST_A;
`ifdef SEQ1011_OVERLAP_EN
            ST_B: w_next_state = in ? ST_B : ST_C;
            ST_C: w_next_state = in ? ST_D : ST_A;
            ST_D: w_next_state = in ? ST_E : ST_C;
`else
            ST_B: w_next_state = in ? ST_A : ST_C;
            ST_C: w_next_state = in ? ST_D : ST_A;
            ST_D: w_next_state = in ? ST_E : ST_A;
`endif
            ST_E: w_next_state = ST_F;
            ST_F: w_next_state = ST_F;
            default: w_next_state = ST_A;
        endcase
    end

    always_ff @(posedge flux) begin
        if (reset) begin
            r_state <= ST_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign A   = (r_state == ST_A);
    assign B   = (r_state == ST_B);
    assign C   = (r_state == ST_C);
    assign D   = (r_state == ST_D);
    assign E   = (r_state == ST_E);
    assign F   = (r_state == ST_F);
    assign out = (r_state == ST_E);

endmodule

// File: tb/tb_seq1011_moore_detector.sv
// Self-checking bench for seq1011_moore_detector: directed steps plus a random one-hot sweep.
module tb_seq1011_moore_detector;

    logic flux;
    logic reset;

    seq1011_moore_detector_if bus ();

    seq1011_moore_detector dut (
        .flux  (flux),
        .reset (reset),
        .in    (bus.in_bit),
        .out   (bus.out),
        .A     (bus.A),
        .B     (bus.B),
        .C     (bus.C),
        .D     (bus.D),
        .E     (bus.E),
        .F     (bus.F)
    );

    // Expected observation vectors, ordered {out, A, B, C, D, E, F}.
    localparam logic [6:0] X_A = 7'b0100000;
    localparam logic [6:0] X_B = 7'b0010000;
    localparam logic [6:0] X_C = 7'b0001000;
    localparam logic [6:0] X_D = 7'b0000100;
    localparam logic [6:0] X_E = 7'b1000010;
    localparam logic [6:0] X_F = 7'b0000001;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    initial flux = 1'b0;
    always #5 flux = ~flux;

    // Reference next-state for the random sweep; states coded 0..5 = A..F.
    function automatic int model_next(input int st, input logic b);
        case (st)
            0: return b ? 1 : 0;
`ifdef SEQ1011_OVERLAP_EN
            1: return b ? 1 : 2;
            3: return b ? 4 : 2;
`else
            1: return b ? 0 : 2;
            3: return b ? 4 : 0;
`endif
            2: return b ? 3 : 0;
            default: return 5;
        endcase
    endfunction

    function automatic logic [6:0] model_vec(input int st);
        case (st)
            0: return X_A;
            1: return X_B;
            2: return X_C;
            3: return X_D;
            4: return X_E;
            default: return X_F;
        endcase
    endfunction

    // Drive one bit, queue its expected result, clock once, then check just after the edge.
    task automatic step(input logic b, input logic rst, input logic [6:0] expv, input string tag);
        logic [6:0] obs;
        logic [6:0] e;
        string      t;
        bus.in_bit = b;
        reset      = rst;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge flux);
        #1;
        obs = {bus.out, bus.A, bus.B, bus.C, bus.D, bus.E, bus.F};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    initial begin
        int ms;
        logic b;
        logic r;
        bus.in_bit = 1'b0;
        reset      = 1'b1;
        @(negedge flux);

        step(1'b1, 1'b1, X_A, "reset");
        step(1'b0, 1'b1, X_A, "reset_hold");

`ifndef SEQ1011_OVERLAP_EN
        // Clean detection, then X input in E and F.
        step(1'b1, 1'b0, X_B, "det_b");
        step(1'b0, 1'b0, X_C, "det_c");
        step(1'b1, 1'b0, X_D, "det_d");
        step(1'b1, 1'b0, X_E, "det_e");
        step(1'bx, 1'b0, X_F, "det_f_x");
        step(1'b1, 1'b0, X_F, "f_sticky1");
        step(1'b0, 1'b0, X_F, "f_sticky0");
        step(1'bx, 1'b1, X_A, "reset_in_f");

        // Mismatch restarts.
        step(1'b0, 1'b0, X_A, "mm0");
        step(1'b1, 1'b0, X_B, "mm1");
        step(1'b1, 1'b0, X_A, "mm2");
        step(1'b1, 1'b0, X_B, "mm3");
        step(1'b0, 1'b0, X_C, "mm4");
        step(1'b0, 1'b0, X_A, "mm5");
        step(1'b1, 1'b0, X_B, "mm6");
        step(1'b0, 1'b0, X_C, "mm7");
        step(1'b1, 1'b0, X_D, "mm8");
        step(1'b0, 1'b0, X_A, "mm9");

        // Reset wins over the completing bit in D.
        step(1'b1, 1'b0, X_B, "mid_b");
        step(1'b0, 1'b0, X_C, "mid_c");
        step(1'b1, 1'b0, X_D, "mid_d");
        step(1'b1, 1'b1, X_A, "reset_in_d");
`else
        step(1'b1, 1'b0, X_B, "ov_b");
        step(1'b1, 1'b0, X_B, "ov_bb");
        step(1'b0, 1'b0, X_C, "ov_c");
        step(1'b1, 1'b0, X_D, "ov_d");
        step(1'b1, 1'b0, X_E, "ov_e");
        step(1'bx, 1'b0, X_F, "ov_f");
        step(1'b0, 1'b1, X_A, "ov_reset");
        step(1'b1, 1'b0, X_B, "ov2_b");
        step(1'b0, 1'b0, X_C, "ov2_c");
        step(1'b1, 1'b0, X_D, "ov2_d");
        step(1'b0, 1'b0, X_C, "ov2_dc");
        step(1'b0, 1'b0, X_A, "ov2_ca");
`endif

        // Random sweep with periodic resets, tracked by the reference model.
        step(1'b0, 1'b1, X_A, "rand_reset");
        ms = 0;
        for (int i = 0; i < 200; i++) begin
            b  = 1'($urandom_range(0, 1));
            r  = (i % 37 == 36);
            ms = r ? 0 : model_next(ms, b);
            step(b, r, model_vec(ms), $sformatf("rand%0d", i));
            n_checks++;
            assert ($onehot({bus.A, bus.B, bus.C, bus.D, bus.E, bus.F})) else begin
                n_fail++;
                $error("FAIL onehot%0d: observed %b expected one bit set", i,
                       {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
